// File: rtl/mat_mem_arbiter_pkg.sv
// Shared calculator definitions used by the matrix-memory arbiter:
// requester indices, default RAM geometry and arbiter FSM encodings.
package mat_mem_arbiter_pkg;

   // Requester indices; bit position in req/gnt/m_en/m_rvalid
   localparam int REQ_INPUT = 0;
   localparam int REQ_ALU   = 1;
   localparam int REQ_DISP  = 2;

   // Default RAM geometry: 4 slots x up to 25 elements, padded to 128 words
   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 16;

   // Arbiter FSM encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_OWNED = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Next requester index, modulo 3
   function automatic logic [1:0] next_idx3(input logic [1:0] idx);
      return (idx == 2'(REQ_DISP)) ? 2'(REQ_INPUT) : idx + 2'd1;
   endfunction

   // One-hot vector for a requester index (index 3 maps to no requester)
   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      logic [2:0] v;
      v = 3'b000;
      case (idx)
         2'd0:    v = 3'b001;
         2'd1:    v = 3'b010;
         2'd2:    v = 3'b100;
         default: v = 3'b000;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/mat_mem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: scans ptr, ptr+1, ptr+2 (mod 3)
// and returns the first eligible requester.
module mat_mem_arbiter_rr_pick3
   import mat_mem_arbiter_pkg::*;
(
   input  logic [2:0] elig,
   input  logic [1:0] ptr,
   output logic [1:0] win,
   output logic       found
);

   logic [3:0] elig4;
   logic [1:0] idx;

   assign elig4 = {1'b0, elig};

   // Walk the three positions starting at the pointer, first hit wins
   always_comb begin
      win   = 2'd0;
      found = 1'b0;
      idx   = (ptr > 2'd2) ? 2'd0 : ptr;
      for (int k = 0; k < 3; k++) begin
         if (!found && elig4[idx]) begin
            win   = idx;
            found = 1'b1;
         end
         idx = next_idx3(idx);
      end
   end

endmodule

// File: rtl/mat_mem_arbiter.sv
// Single-port matrix RAM arbiter for the input parser, ALU and display engine.
//
// Ownership handshake: a master raises req[i] and holds it for its whole
// burst. gnt[i] (registered, one-hot) tells it that it owns the RAM; in any
// cycle with gnt[i] & m_en[i] its access hits the RAM in that same cycle.
// The burst ends when the master drops req[i]: an access in the cycle req
// falls is still honoured, gnt falls on the next edge, one DRAIN cycle
// follows, and arbitration resumes. Reads return one cycle later on
// m_rvalid[i]/m_rdata, even if ownership has been lost by then.
module mat_mem_arbiter
   import mat_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 4096
)(
   input  logic                  sys_clk_in,
   input  logic                  sys_rst_n,
   input  logic [2:0]            req,
   output logic [2:0]            gnt,
   input  logic [2:0]            m_en,
   input  logic [2:0]            m_we,
   input  logic [3*ADDR_W-1:0]   m_addr,
   input  logic [3*DATA_W-1:0]   m_wdata,
   output logic [2:0]            m_rvalid,
   output logic [DATA_W-1:0]     m_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic [1:0]            owner,
   output logic                  busy,
   output logic                  err_timeout,
   output logic [1:0]            state_dbg
);

   // Hold counter only needs to reach TIMEOUT-1
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [1:0]       rr_ptr;
   logic [2:0]       blocked;
   logic [CNT_W-1:0] hold_cnt;
   logic             rd_pend;
   logic [1:0]       rd_tag;
   logic [2:0]       elig;
   logic [1:0]       pick_win;
   logic             pick_found;
   logic [3:0]       req4;
   logic             owner_req;

   // A master that was timed out stays out until it lets go of req
   assign elig      = req & ~blocked;
   assign req4      = {1'b0, req};
   assign owner_req = req4[owner];
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;
   assign m_rdata   = ram_rdata;

   mat_mem_arbiter_rr_pick3 u_pick (
      .elig  (elig),
      .ptr   (rr_ptr),
      .win   (pick_win),
      .found (pick_found)
   );

   // Ownership FSM, round-robin pointer, watchdog and read-tag pipeline
   always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= ST_IDLE;
         gnt         <= 3'b000;
         owner       <= 2'd0;
         rr_ptr      <= 2'd0;
         blocked     <= 3'b000;
         hold_cnt    <= '0;
         err_timeout <= 1'b0;
         rd_pend     <= 1'b0;
         rd_tag      <= 2'd0;
      end else begin
         err_timeout <= 1'b0;
         blocked     <= blocked & req;
         rd_pend     <= ram_en & ~ram_we;
         rd_tag      <= owner;
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  owner    <= pick_win;
                  gnt      <= onehot3(pick_win);
                  hold_cnt <= '0;
                  state    <= ST_OWNED;
               end
            end
            ST_OWNED: begin
               if (!owner_req) begin
                  gnt    <= 3'b000;
                  rr_ptr <= next_idx3(owner);
                  state  <= ST_DRAIN;
               end else if ((TIMEOUT != 0) && (hold_cnt == CNT_LAST)) begin
                  gnt         <= 3'b000;
                  rr_ptr      <= next_idx3(owner);
                  state       <= ST_DRAIN;
                  err_timeout <= 1'b1;
                  blocked     <= (blocked & req) | onehot3(owner);
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               state <= ST_IDLE;
            end
            default: begin
               gnt   <= 3'b000;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Route the owner's access onto the RAM port; everything else is silenced
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      for (int i = 0; i < 3; i++) begin
         if ((state == ST_OWNED) && (owner == 2'(i)) && m_en[i]) begin
            ram_en    = 1'b1;
            ram_we    = m_we[i];
            ram_addr  = m_addr[i*ADDR_W +: ADDR_W];
            ram_wdata = m_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Steer the read-valid strobe to the master that issued last cycle's read
   always_comb begin
      m_rvalid = 3'b000;
      if (rd_pend) m_rvalid = onehot3(rd_tag);
   end

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Directed self-checking bench for mat_mem_arbiter with a 1-cycle RAM model.
module tb_mat_mem_arbiter;

   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 8;

   logic                 sys_clk_in = 1'b0;
   logic                 sys_rst_n;
   logic [2:0]           req;
   logic [2:0]           gnt;
   logic [2:0]           m_en;
   logic [2:0]           m_we;
   logic [3*ADDR_W-1:0]  m_addr;
   logic [3*DATA_W-1:0]  m_wdata;
   logic [2:0]           m_rvalid;
   logic [DATA_W-1:0]    m_rdata;
   logic                 ram_en;
   logic                 ram_we;
   logic [ADDR_W-1:0]    ram_addr;
   logic [DATA_W-1:0]    ram_wdata;
   logic [DATA_W-1:0]    ram_rdata;
   logic [1:0]           owner;
   logic                 busy;
   logic                 err_timeout;
   logic [1:0]           state_dbg;

   logic [DATA_W-1:0]    ram_mem [0:127];

   int checks   = 0;
   int failures = 0;

   mat_mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk_in  (sys_clk_in),
      .sys_rst_n   (sys_rst_n),
      .req         (req),
      .gnt         (gnt),
      .m_en        (m_en),
      .m_we        (m_we),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rvalid    (m_rvalid),
      .m_rdata     (m_rdata),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .owner       (owner),
      .busy        (busy),
      .err_timeout (err_timeout),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   always #5 sys_clk_in = ~sys_clk_in;

   // single-port RAM with one-cycle read latency
   always @(posedge sys_clk_in) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   // driver tasks
   task automatic clear_inputs();
      req     = 3'b000;
      m_en    = 3'b000;
      m_we    = 3'b000;
      m_addr  = '0;
      m_wdata = '0;
   endtask

   task automatic drive_m(input int i, input logic en, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      m_en[i] = en;
      m_we[i] = we;
      m_addr[i*ADDR_W +: ADDR_W]  = a;
      m_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic apply_reset();
      @(negedge sys_clk_in);
      sys_rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge sys_clk_in);
      sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
      checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", m_rvalid); end
      checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
      checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
      sys_rst_n = 1'b1;
      @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_idle_gnt got=%b exp=000", gnt); end
   endtask

   task automatic test_single();
      apply_reset();
      req = 3'b010;
      #1;
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL single_pre_gnt got=%b exp=000", gnt); end
      @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL single_gnt got=%b exp=010", gnt); end
      checks++; if (owner !== 2'd1) begin failures++; $display("FAIL single_owner got=%0d exp=1", owner); end
      drive_m(1, 1'b1, 1'b1, 7'd5, 16'h000A);
      #1;
      checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin failures++; $display("FAIL single_wr_ctl got=%b%b exp=11", ram_en, ram_we); end
      checks++; if (ram_addr !== 7'd5) begin failures++; $display("FAIL single_wr_addr got=%0d exp=5", ram_addr); end
      checks++; if (ram_wdata !== 16'h000A) begin failures++; $display("FAIL single_wr_data got=%h exp=000a", ram_wdata); end
      @(negedge sys_clk_in);
      drive_m(1, 1'b1, 1'b0, 7'd5, 16'h0000);
      #1;
      checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin failures++; $display("FAIL single_rd_ctl got=%b%b exp=10", ram_en, ram_we); end
      @(negedge sys_clk_in);
      drive_m(1, 1'b0, 1'b0, 7'd0, 16'h0000);
      req = 3'b000;
      #1;
      checks++; if (m_rvalid !== 3'b010) begin failures++; $display("FAIL single_rvalid got=%b exp=010", m_rvalid); end
      checks++; if (m_rdata !== 16'h000A) begin failures++; $display("FAIL single_rdata got=%h exp=000a", m_rdata); end
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL single_gnt_drop_cycle got=%b exp=010", gnt); end
      @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL single_drain_gnt got=%b exp=000", gnt); end
      checks++; if (busy !== 1'b1 || state_dbg !== 2'd2) begin failures++; $display("FAIL single_drain_state got=%b/%0d exp=1/2", busy, state_dbg); end
      @(negedge sys_clk_in);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
      checks++; if (owner !== 2'd1) begin failures++; $display("FAIL single_owner_hold got=%0d exp=1", owner); end
   endtask

   task automatic test_contention();
      int n = 0;
      int cyc [3];
      logic [2:0] g [3];
      for (int k = 0; k < 3; k++) begin cyc[k] = 0; g[k] = 3'b000; end
      apply_reset();
      req = 3'b111;
      for (int c = 0; c < 30 && n < 3; c++) begin
         @(negedge sys_clk_in);
         if (gnt != 3'b000) begin
            checks++; if (!$onehot(gnt)) begin failures++; $display("FAIL contention_onehot got=%b exp=onehot", gnt); end
            g[n] = gnt;
            cyc[n] = c;
            n++;
            req = req & ~gnt;
         end
      end
      checks++; if (n != 3) begin failures++; $display("FAIL contention_count got=%0d exp=3", n); end
      checks++; if (cyc[0] != 0) begin failures++; $display("FAIL contention_latency got=%0d exp=0", cyc[0]); end
      checks++; if (g[0] !== 3'b001) begin failures++; $display("FAIL contention_g0 got=%b exp=001", g[0]); end
      checks++; if (g[1] !== 3'b010) begin failures++; $display("FAIL contention_g1 got=%b exp=010", g[1]); end
      checks++; if (g[2] !== 3'b100) begin failures++; $display("FAIL contention_g2 got=%b exp=100", g[2]); end
      checks++; if (cyc[1] - cyc[0] - 1 != 2) begin failures++; $display("FAIL contention_gap01 got=%0d exp=2", cyc[1] - cyc[0] - 1); end
      checks++; if (cyc[2] - cyc[1] - 1 != 2) begin failures++; $display("FAIL contention_gap12 got=%0d exp=2", cyc[2] - cyc[1] - 1); end
   endtask

   task automatic test_fairness();
      int n = 0;
      logic [2:0] reraise = 3'b000;
      logic [2:0] g [6];
      for (int k = 0; k < 6; k++) g[k] = 3'b000;
      apply_reset();
      req = 3'b011;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge sys_clk_in);
         req = req | reraise;
         reraise = 3'b000;
         if (gnt != 3'b000) begin
            g[n] = gnt;
            n++;
            req = req & ~gnt;
            reraise = gnt;
         end
      end
      checks++; if (n != 6) begin failures++; $display("FAIL fairness_count got=%0d exp=6", n); end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (g[k] !== ((k % 2 == 0) ? 3'b001 : 3'b010)) begin
            failures++; $display("FAIL fairness_g%0d got=%b exp=%b", k, g[k], (k % 2 == 0) ? 3'b001 : 3'b010);
         end
      end
      for (int k = 1; k < 6; k++) begin
         checks++; if (g[k] === g[k-1]) begin failures++; $display("FAIL fairness_repeat%0d got=%b exp=not %b", k, g[k], g[k-1]); end
      end
   endtask

   task automatic test_non_owner();
      apply_reset();
      req = 3'b010;
      @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL nonowner_gnt got=%b exp=010", gnt); end
      for (int k = 0; k < 4; k++) begin
         drive_m(1, 1'b1, 1'b0, 7'(10 + k), 16'h0000);
         drive_m(2, (k % 2 == 0), 1'b1, 7'd77, 16'hBEEF);
         #1;
         checks++; if (ram_addr !== 7'(10 + k)) begin failures++; $display("FAIL nonowner_addr%0d got=%0d exp=%0d", k, ram_addr, 10 + k); end
         checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL nonowner_we%0d got=%b exp=0", k, ram_we); end
         checks++; if (m_rvalid[2] !== 1'b0) begin failures++; $display("FAIL nonowner_rvalid2_%0d got=%b exp=0", k, m_rvalid[2]); end
         if (k > 0) begin
            checks++; if (m_rvalid !== 3'b010) begin failures++; $display("FAIL nonowner_rvalid1_%0d got=%b exp=010", k, m_rvalid); end
         end
         @(negedge sys_clk_in);
      end
      // last owner access in the cycle req falls, then DRAIN
      req = 3'b000;
      drive_m(1, 1'b1, 1'b0, 7'd20, 16'h0000);
      drive_m(2, 1'b1, 1'b0, 7'd77, 16'h0000);
      #1;
      checks++; if (ram_en !== 1'b1 || ram_addr !== 7'd20) begin failures++; $display("FAIL nonowner_last_access got=%b/%0d exp=1/20", ram_en, ram_addr); end
      @(negedge sys_clk_in);
      #1;
      checks++; if (ram_en !== 1'b0 || ram_addr !== 7'd0) begin failures++; $display("FAIL nonowner_drain_ram got=%b/%0d exp=0/0", ram_en, ram_addr); end
      checks++; if (m_rvalid !== 3'b010) begin failures++; $display("FAIL nonowner_late_rvalid got=%b exp=010", m_rvalid); end
      @(negedge sys_clk_in);
      #1;
      checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL nonowner_rvalid_clear got=%b exp=000", m_rvalid); end
      clear_inputs();
   endtask

   task automatic test_watchdog();
      int hi_cnt = 0;
      int err_cnt = 0;
      int err_c = -1;
      int first = -1;
      apply_reset();
      req = 3'b001;
      for (int c = 0; c < 30; c++) begin
         @(negedge sys_clk_in);
         if (gnt[0]) begin
            hi_cnt++;
            if (first < 0) first = c;
         end
         if (err_timeout) begin
            err_cnt++;
            err_c = c;
         end
      end
      checks++; if (first != 0) begin failures++; $display("FAIL watchdog_first got=%0d exp=0", first); end
      checks++; if (hi_cnt != TIMEOUT) begin failures++; $display("FAIL watchdog_hold got=%0d exp=%0d", hi_cnt, TIMEOUT); end
      checks++; if (err_cnt != 1) begin failures++; $display("FAIL watchdog_err_count got=%0d exp=1", err_cnt); end
      checks++; if (err_c != TIMEOUT) begin failures++; $display("FAIL watchdog_err_cycle got=%0d exp=%0d", err_c, TIMEOUT); end
      checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL watchdog_blocked got=%b/%b exp=000/0", gnt, busy); end
      req = 3'b000;
      @(negedge sys_clk_in);
      req = 3'b001;
      @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL watchdog_regrant got=%b exp=001", gnt); end
      req = 3'b000;
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      req = 3'b010;
      @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL rstread_gnt got=%b exp=010", gnt); end
      drive_m(1, 1'b1, 1'b0, 7'd5, 16'h0000);
      @(negedge sys_clk_in);
      drive_m(1, 1'b0, 1'b0, 7'd0, 16'h0000);
      #1;
      checks++; if (m_rvalid !== 3'b010) begin failures++; $display("FAIL rstread_pre_rvalid got=%b exp=010", m_rvalid); end
      sys_rst_n = 1'b0;
      #1;
      checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL rstread_rvalid got=%b exp=000", m_rvalid); end
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL rstread_gnt_clr got=%b exp=000", gnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstread_busy got=%b exp=0", busy); end
      clear_inputs();
      @(negedge sys_clk_in);
      sys_rst_n = 1'b1;
      req = 3'b001;
      @(negedge sys_clk_in);
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rstread_regrant got=%b exp=001", gnt); end
      checks++; if (m_rvalid !== 3'b000) begin failures++; $display("FAIL rstread_stale_rvalid got=%b exp=000", m_rvalid); end
      clear_inputs();
   endtask

   // global time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "time limit");
   end

   // test sequence and report
   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_non_owner();
      test_watchdog();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
